// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - buffers A/B and feeds them diagonally skewed into the west/north edge of an NxN systolic MAC array
module systolic_feeder #(
    parameter int N      = 2,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [2*$clog2(N)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic [N*DATA_W-1:0]      a_out,
    output logic [N*DATA_W-1:0]      b_out,
    output logic                     clear_out,
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(3*N+1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2*N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(3*N+1);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;

    state_t              st;
    logic [CW-1:0]       cnt;
    logic [DATA_W-1:0]   a_mem [N*N];
    logic [DATA_W-1:0]   b_mem [N*N];
    logic [N*DATA_W-1:0] a_nxt;
    logic [N*DATA_W-1:0] b_nxt;

    // cnt holds the number of the edge about to occur; feed step k = cnt - 2.
    // A[i][c] and B[c][i] both belong to step k = i + c, so one match covers both edges.
    always_comb begin
        a_nxt = '0;
        b_nxt = '0;
        if (st == FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int c = 0; c < N; c++) begin
                    if (cnt == CW'(i + c + 2)) begin
                        a_nxt[i*DATA_W +: DATA_W] = a_mem[i*N + c];
                        b_nxt[i*DATA_W +: DATA_W] = b_mem[c*N + i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= '0;
            a_out     <= '0;
            b_out     <= '0;
            clear_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < N*N; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else begin
            case (st)
                IDLE: begin
                    done <= 1'b0;
                    if (wr_en) begin
                        if (wr_sel) b_mem[wr_addr] <= wr_data;
                        else        a_mem[wr_addr] <= wr_data;
                    end
                    if (start) begin
                        st   <= CLEAR;
                        cnt  <= CW'(1);
                        busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    clear_out <= 1'b1;
                    st        <= FEED;
                    cnt       <= cnt + 1'b1;
                end
                FEED: begin
                    clear_out <= 1'b0;
                    a_out     <= a_nxt;
                    b_out     <= b_nxt;
                    cnt       <= cnt + 1'b1;
                    if (cnt == FEED_LAST) st <= DRAIN;
                end
                DRAIN: begin
                    a_out <= '0;
                    b_out <= '0;
                    // cnt parks at its last value instead of wrapping
                    if (cnt == DRAIN_LAST) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - directed self-checking bench for systolic_feeder with a 2x2 PE grid attached
module tb_systolic_feeder;
    localparam int N  = 2;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        start = 1'b0;
    logic [15:0] a_out;
    logic [15:0] b_out;
    logic        clear_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .start(start),
        .a_out(a_out), .b_out(b_out), .clear_out(clear_out),
        .busy(busy), .done(done)
    );

    // 2x2 PE grid: a moves east, b moves south, c accumulates a*b
    logic [7:0]  pa [2][2];
    logic [7:0]  pb [2][2];
    logic [31:0] pc [2][2];
    logic [7:0]  ain [2][2];
    logic [7:0]  bin [2][2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ain[i][0] = a_out[i*8 +: 8];
            ain[i][1] = pa[i][0];
            bin[0][i] = b_out[i*8 +: 8];
            bin[1][i] = pb[0][i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (rst) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end else begin
                    pa[i][j] <= ain[i][j];
                    pb[i][j] <= bin[i][j];
                    pc[i][j] <= clear_out ? 32'd0 : pc[i][j] + ain[i][j] * bin[i][j];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [1:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Starts a run (start sampled on the next edge) and checks edges 1..7.
    task automatic run_check(input bit zero_ops, input bit guards, input bit pe_chk);
        logic [15:0] ea [8];
        logic [15:0] eb [8];
        for (int e = 0; e < 8; e++) begin ea[e] = '0; eb[e] = '0; end
        if (!zero_ops) begin
            ea[2] = 16'h0001; eb[2] = 16'h0005;
            ea[3] = 16'h0302; eb[3] = 16'h0607;
            ea[4] = 16'h0400; eb[4] = 16'h0800;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("e%0d a_out", e), a_out, ea[e]);
            check($sformatf("e%0d b_out", e), b_out, eb[e]);
            check($sformatf("e%0d clear", e), clear_out, (e == 1));
            check($sformatf("e%0d busy", e), busy, (e != 7));
            check($sformatf("e%0d done", e), done, (e == 7));
            if (guards && e == 2) begin
                start = 1'b1;
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'd9;
            end
            if (guards && e == 3) begin
                start = 1'b0;
                wr_en = 1'b0;
            end
        end
        if (pe_chk) begin
            check("pe c00", pc[0][0], 32'd19);
            check("pe c01", pc[0][1], 32'd22);
            check("pe c10", pc[1][0], 32'd43);
            check("pe c11", pc[1][1], 32'd50);
        end
    endtask

    initial begin
        // reset state
        repeat (2) tick();
        check("rst a_out", a_out, 0);
        check("rst b_out", b_out, 0);
        check("rst clear", clear_out, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst = 1'b0;
        tick();
        check("post-rst busy", busy, 0);

        // async reset mid-cycle during a run
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("pre-async busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("async busy", busy, 0);
        check("async clear", clear_out, 0);
        check("async done", done, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("no done after rst", done, 0);
        end

        // load A=[[1,2],[3,4]], B=[[5,6],[7,8]]
        wr(1'b0, 2'd0, 8'd1); wr(1'b0, 2'd1, 8'd2);
        wr(1'b0, 2'd2, 8'd3); wr(1'b0, 2'd3, 8'd4);
        wr(1'b1, 2'd0, 8'd5); wr(1'b1, 2'd1, 8'd6);
        wr(1'b1, 2'd2, 8'd7); wr(1'b1, 2'd3, 8'd8);

        // skew sequence plus PE integration
        run_check(1'b0, 1'b0, 1'b1);
        tick();
        check("idle after done", done, 0);

        // busy guards, then back-to-back rerun from the done cycle
        run_check(1'b0, 1'b1, 1'b0);
        run_check(1'b0, 1'b0, 1'b1);

        // abort during feed step 1, buffers must come back zeroed
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        check("pre-abort a_out", a_out, 16'h0302);
        #3 rst = 1'b1;
        #1;
        check("abort a_out", a_out, 0);
        check("abort b_out", b_out, 0);
        check("abort busy", busy, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("abort no done", done, 0);
        end
        run_check(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
